// File: rtl/led_mode_sequencer_if.sv
// rtl/led_mode_sequencer_if.sv - board I/O bundle for the LED mode sequencer
// Switches and button flow into the sequencer; LEDs and mode flow out.
interface led_mode_sequencer_if;
  logic [3:0] sw;
  logic       btn;
  logic [3:0] led;
  logic [1:0] mode;

  modport master (output sw, output btn, input led, input mode);
  modport slave  (input sw, input btn, output led, output mode);
endinterface

// File: rtl/led_mode_sequencer.sv
// rtl/led_mode_sequencer.sv - switch/button sync, button debounce, 4-mode LED sequencer
// Modes cycle PASS -> COUNT -> CHASE -> BLINK on each debounced press; a prescaler paces animation.
module led_mode_sequencer #(
  parameter int TICK_DIV   = 31_250_000,
  parameter int DEB_CYCLES = 1_250_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  led_mode_sequencer_if.slave  bus
);
  localparam int TW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEB_CYCLES);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    MODE_PASS  = 2'd0,
    MODE_COUNT = 2'd1,
    MODE_CHASE = 2'd2,
    MODE_BLINK = 2'd3
  } mode_e;

  logic [3:0]    sw_meta_q, sw_s_q;
  logic          btn_meta_q, btn_s_q;
  logic          btn_db_q, btn_db_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic [TW-1:0] presc_q, presc_d;
  logic          phase_q, phase_d;
  mode_e         mode_q, mode_d, mode_next;
  logic [3:0]    led_q, led_d;
  logic          press, tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta_q  <= '0;
      sw_s_q     <= '0;
      btn_meta_q <= 1'b0;
      btn_s_q    <= 1'b0;
      btn_db_q   <= 1'b0;
      deb_cnt_q  <= '0;
      presc_q    <= '0;
      phase_q    <= 1'b1;
      mode_q     <= MODE_PASS;
      led_q      <= '0;
    end else begin
      sw_meta_q  <= bus.sw;
      sw_s_q     <= sw_meta_q;
      btn_meta_q <= bus.btn;
      btn_s_q    <= btn_meta_q;
      btn_db_q   <= btn_db_d;
      deb_cnt_q  <= deb_cnt_d;
      presc_q    <= presc_d;
      phase_q    <= phase_d;
      mode_q     <= mode_d;
      led_q      <= led_d;
    end
  end

  always_comb begin
    btn_db_d  = btn_db_q;
    deb_cnt_d = '0;
    press     = 1'b0;
    // Any cycle where the synced level agrees with the debounced one restarts the count.
    if (btn_s_q != btn_db_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        btn_db_d = btn_s_q;
        press    = btn_s_q;
      end else begin
        deb_cnt_d = deb_cnt_q + DW'(1);
      end
    end

    tick      = (presc_q == TICK_LAST);
    presc_d   = (tick || press) ? '0 : presc_q + TW'(1);
    mode_next = mode_e'(mode_q + 2'd1);
    mode_d    = mode_q;
    led_d     = led_q;
    phase_d   = phase_q;

    // A press overrides a coincident tick: entry values load, the step is dropped.
    if (press) begin
      mode_d  = mode_next;
      phase_d = 1'b1;
      case (mode_next)
        MODE_COUNT: led_d = 4'b0000;
        MODE_CHASE: led_d = 4'b0001;
        MODE_BLINK: led_d = sw_s_q;
        MODE_PASS:  led_d = sw_s_q;
      endcase
    end else begin
      case (mode_q)
        MODE_PASS:  led_d = sw_s_q;
        MODE_COUNT: if (tick && !sw_s_q[1]) led_d = led_q + 4'd1;
        MODE_CHASE: if (tick) led_d = sw_s_q[0] ? {led_q[0], led_q[3:1]} : {led_q[2:0], led_q[3]};
        MODE_BLINK: begin
          if (tick) phase_d = ~phase_q;
          led_d = phase_d ? sw_s_q : 4'b0000;
        end
      endcase
    end
  end

  assign bus.led  = led_q;
  assign bus.mode = mode_q;
endmodule

// File: tb/tb_led_mode_sequencer.sv
// tb/tb_led_mode_sequencer.sv - scoreboard bench for led_mode_sequencer (TICK_DIV=4, DEB_CYCLES=3)
module tb_led_mode_sequencer;
  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  typedef struct {
    int         due;
    logic [3:0] led;
    logic [1:0] mode;
    string      tag;
  } exp_t;
  exp_t sb[$];

  led_mode_sequencer_if bus ();

  led_mode_sequencer #(.TICK_DIV(4), .DEB_CYCLES(3)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input int due, input logic [3:0] l, input logic [1:0] m, input string tag);
    exp_t e;
    e.due = due; e.led = l; e.mode = m; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic nx(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic nx_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due < cyc) begin
        chk({sb[i].tag, "_late"}, cyc, sb[i].due);
        sb.delete(i);
      end else if (sb[i].due == cyc) begin
        chk({sb[i].tag, "_led"}, bus.led, sb[i].led);
        chk({sb[i].tag, "_mode"}, bus.mode, sb[i].mode);
        sb.delete(i);
      end
    end
  end

  int c, c0, p, p2, p3, p4, p5, h, d;
  logic [3:0] chase_tbl [12];
  logic [3:0] v;

  initial begin
    chase_tbl = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010,
                  4'b0100, 4'b0010, 4'b0001, 4'b1000, 4'b0100, 4'b0010};
    rst_n = 1'b0; bus.sw = 4'b0000; bus.btn = 1'b0;
    nx(3);
    chk("reset_led", bus.led, 4'b0000);
    chk("reset_mode", bus.mode, 2'd0);

    rst_n = 1'b1; bus.sw = 4'b0011;
    nx(6);
    chk("run_pass_led", bus.led, 4'b0011);

    // Reset mid-run, release with sw=1010
    rst_n = 1'b0; bus.sw = 4'b1010;
    #1;
    chk("rst_async_led", bus.led, 4'b0000);
    chk("rst_async_mode", bus.mode, 2'd0);
    nx(2);
    c = cyc;
    push(c + 1, 4'b0000, 2'd0, "rel_1");
    push(c + 2, 4'b0000, 2'd0, "rel_2");
    push(c + 3, 4'b1010, 2'd0, "pass_a");
    rst_n = 1'b1;
    nx(4);
    c = cyc; bus.sw = 4'b0101;
    push(c + 2, 4'b1010, 2'd0, "pass_hold");
    push(c + 3, 4'b0101, 2'd0, "pass_b");
    nx(4);

    // Bounce then hold; press lands 4 edges after the stable capture
    c = cyc; bus.sw = 4'b0000;
    push(c + 3, 4'b0000, 2'd0, "pass_zero");
    nx(4);
    c0 = cyc;
    p  = c0 + 13;
    for (int t = c0 + 1; t < p; t++) push(t, 4'b0000, 2'd0, "bounce");
    push(p, 4'b0000, 2'd1, "press1");
    for (int t = p + 1; t <= p + 92; t++) begin
      d = t - p;
      if (d < 64)      v = 4'((d / 4) % 16);
      else if (d < 80) v = 4'd0;
      else             v = 4'(1 + (d - 80) / 4);
      push(t, v, 2'd1, "count");
    end
    for (int i = 0; i < 8; i++) begin
      bus.btn = (i % 2 == 0);
      nx(1);
    end
    bus.btn = 1'b1;
    nx_to(p + 10); bus.btn = 1'b0;
    nx_to(p + 65); bus.sw = 4'b0010;
    nx_to(p + 77); bus.sw = 4'b0000;

    // CHASE: left rotation, then right after sw[0]=1 at 0100
    nx_to(p + 88);
    p2 = p + 93;
    for (int t = p2; t <= p2 + 44; t++) push(t, chase_tbl[(t - p2) / 4], 2'd2, "chase");
    bus.btn = 1'b1;
    nx_to(p2 + 2);  bus.btn = 1'b0;
    nx_to(p2 + 25); bus.sw = 4'b0001;

    // BLINK with sw=1111
    nx_to(p2 + 40);
    p3 = p2 + 45;
    for (int t = p3; t <= p3 + 28; t++)
      push(t, (((t - p3) / 4) % 2 == 0) ? 4'b1111 : 4'b0000, 2'd3, "blink");
    bus.sw = 4'b1111; bus.btn = 1'b1;
    nx_to(p3 + 2); bus.btn = 1'b0;

    // Fourth press wraps to PASS
    nx_to(p3 + 24);
    p4 = p3 + 29;
    for (int t = p4; t <= p4 + 3; t++)        push(t, 4'b1111, 2'd0, "wrap_pass");
    for (int t = p4 + 4; t <= p4 + 13; t++)   push(t, 4'b0110, 2'd0, "wrap_sw");
    push(p4 + 14, 4'b0000, 2'd0, "pre_coin");
    push(p4 + 15, 4'b0000, 2'd0, "pre_coin");
    bus.btn = 1'b1;
    nx_to(p4 + 1); bus.sw = 4'b0110;
    nx_to(p4 + 2); bus.btn = 1'b0;

    // Press coincident with a tick edge (ticks at p4+4k)
    nx_to(p4 + 11);
    p5 = p4 + 16;
    for (int t = p5; t <= p5 + 15; t++) push(t, 4'((t - p5) / 4), 2'd1, "coin_count");
    bus.sw = 4'b0000; bus.btn = 1'b1;
    nx_to(p5 + 2); bus.btn = 1'b0;

    // Reset pulse with debounce counter at 2 and button held
    nx_to(p5 + 12);
    h = cyc;
    for (int t = h + 5; t <= h + 10; t++) push(t, 4'b0000, 2'd0, "post_rst");
    for (int t = h + 11; t <= h + 14; t++) push(t, 4'b0000, 2'd1, "redeb_entry");
    push(h + 15, 4'b0001, 2'd1, "redeb_step");
    bus.btn = 1'b1;
    nx_to(h + 4);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_led", bus.led, 4'b0000);
    chk("rst_mid_mode", bus.mode, 2'd0);
    nx_to(h + 6);
    rst_n = 1'b1;
    nx_to(h + 16);

    for (int i = 0; i < 50 && sb.size() != 0; i++) nx(1);
    chk("sb_drain", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/led_mode_sequencer.md
# led_mode_sequencer

Board-level LED pattern controller for the 4-switch/4-LED test design. It synchronises the slide switches and a mode push-button, debounces the button, and sequences four display modes on the LEDs: switch pass-through, binary count, one-hot chase, and blink. A free-running prescaler paces the animated modes. It sits between the board I/O pins and the LED outputs and replaces direct switch-to-LED wiring.

## Interface
- TICK_DIV, 31_250_000: prescaler period in clk cycles (4 Hz at 125 MHz); ≥2
- DEB_CYCLES, 1_250_000: consecutive stable cycles required to accept a button change (10 ms); ≥2
- clk  in  1  master clock
- rst_n  in  1  asynchronous active-low reset
- sw  in  4  raw slide switches (asynchronous)
- btn  in  1  raw mode push-button, active-high (asynchronous, bouncing)
- led  out  4  LED drive, registered
- mode  out  2  current mode, registered: 0 PASS, 1 COUNT, 2 CHASE, 3 BLINK

## Operation
- Reset (asynchronous assert, synchronous release by design): led=0, mode=0 (PASS), sync flops=0, btn_db=0, debounce counter=0, prescaler=0, blink phase=1.
- Synchronisers: sw and btn each pass through 2 flops, giving sw_s and btn_s.
- Debounce: on each edge where btn_s≠btn_db, if cnt==DEB_CYCLES-1 then btn_db flips and cnt←0, else cnt++. On any edge where btn_s==btn_db, cnt←0.
- Press = the edge where btn_db goes 0→1. At that same edge mode←mode+1 (mod 4, 3→0). A release does not change mode.
- Mode entry (same edge as mode change): prescaler←0. Load led as follows: COUNT 4'b0000, CHASE 4'b0001, BLINK sw_s (phase←1), PASS sw_s.
- Prescaler: counts 0..TICK_DIV-1 and wraps. tick=1 for the cycle the count equals TICK_DIV-1. Free-running except when cleared on mode entry.
- PASS: led←sw_s every cycle and ignores tick.
- COUNT: on tick, led←led+1 (4-bit wrap, 15→0). If sw_s[1]=1, the count holds.
- CHASE: on tick, the one-hot rotates. sw_s[0]=0 rotates left (0001→0010→…→1000→0001); sw_s[0]=1 rotates right. Direction is sampled live at each tick.
- BLINK: phase toggles on tick. While phase=1, led←sw_s every cycle. While phase=0, led←0.
- Simultaneous press and tick: the press wins. Mode entry values load and the tick is discarded.
- rst_n asserted mid-mode or mid-debounce: all state returns to reset values immediately. No press is generated on release.

## Timing
- sw→led in PASS: 3 edges (2 sync + output register).
- btn rising, held stable, first captured at edge 0: btn_s high after edge 1, btn_db and mode update at edge DEB_CYCLES+1.
- Bounce: any btn_s glitch shorter than DEB_CYCLES cycles produces no press and clears the counter.
- First animated update after mode entry at edge E: at edge E+TICK_DIV, then every TICK_DIV cycles.
- Blink period is 2·TICK_DIV cycles with a 50% duty.
- mode and led are glitch-free flop outputs, and both change on the same edge at mode entry.

## Test plan
Use TICK_DIV=4 and DEB_CYCLES=3.
- Reset and pass-through: assert rst_n=0 mid-run, then release with sw=4'b1010. led=0 and mode=0 during reset; led=4'b1010 three edges after sw settles; sw→4'b0101 gives led=4'b0101 three edges later.
- Debounce: btn toggles 1,0,1,0 every cycle for 8 cycles, then holds 1. No mode change during the bounce; mode=1 exactly 4 edges after the btn_s-stable capture; holding and releasing produces no further change.
- COUNT wrap and hold: enter COUNT with sw=0. led=0 at entry, then 1,2,…,15,0 every 4 cycles. Set sw[1]=1 and led freezes; clear it and counting resumes.
- CHASE direction: second press with sw=0 gives led 0001 at entry, then 0010, 0100, 1000, 0001 every 4 cycles. Set sw[0]=1 at 0100 and the next tick gives 0010.
- BLINK and wrap-around: third press with sw=4'b1111 gives led=1111 for 4 cycles, 0000 for 4, and repeats. A fourth press returns mode to 0 and led=sw_s.
- Press coincident with tick, and reset mid-debounce: time the debounced press on a tick edge. The new mode's entry value appears and no pattern step occurs. Pulse rst_n low with cnt=2 and btn held: mode stays 0 after reset until a full new debounce completes.
